max_search_tree: RTL
====================

# max_search_tree

Parametrised, pipelined two's-complement maximum search with index reporting, for multi-h trellis metric selection. It takes NUM_IN signed metrics per beat through a registered comparison tree. A running-maximum stage then extends the search across multi-beat frames, so one block covers the 4-way case and the wider 16/32/64-candidate multi-h searches. The output is the frame's maximum value and its offset index, one pulse per frame.

## Interface
- WIDTH, 8, metric width, two's complement
- NUM_IN, 4, candidates per beat; power of 2, 2..16
- INDEX_W, 6, index width (0..63 covers multi-h)
- INDEX_OFFSET, 0, constant added to every reported index
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  beat qualifier
- in_first  in  1  first beat of frame (valid only with in_valid)
- in_last  in  1  last beat of frame (valid only with in_valid)
- in_data  in  NUM_IN*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  one-cycle pulse: frame result ready
- out_max  out  WIDTH  frame maximum
- out_index  out  INDEX_W  global candidate index + INDEX_OFFSET, mod 2^INDEX_W
- out_overflow  out  1  some candidate's unwrapped index in the frame exceeded 2^INDEX_W-1

## Operation
- Compare is signed (two's complement); ties go to the lower global index, in the tree and in the accumulator.
- Tree: L = log2(NUM_IN) levels, pairwise compare per level, one register per level. Each node carries value, lane index and a beat tag (first, last, valid).
- Beat counter: cleared on a first beat, incremented on each valid beat. Global index = beat*NUM_IN + lane.
- Accumulator, fed by the tree output:
  - On a first-tagged beat it loads the beat winner.
  - On any other beat it replaces the held winner only if the new value is strictly greater.
- out_overflow is sticky per frame. It is set if (beat*NUM_IN + NUM_IN-1 + INDEX_OFFSET) ≥ 2^INDEX_W for any beat.
- Frame states: IDLE, ACTIVE.
  - IDLE → ACTIVE on a valid beat without last.
  - ACTIVE → IDLE on a valid last beat.
  - A valid beat in IDLE without in_first is treated as first.
  - in_first during ACTIVE abandons the open frame; no output is produced for it, and the new frame starts.
  - first&last together is a single-beat frame.
- No backpressure. One beat per cycle is accepted; back-to-back frames are allowed with no gap.

## Timing
- Latency: valid last beat at cycle T → out_valid at T+L+1.
  - L tree registers plus the accumulator/output register.
  - For NUM_IN=4, out_valid rises at T+3.
- out_valid is high for exactly one cycle per completed frame.
- out_max, out_index and out_overflow update only with out_valid and hold until the next result.
- Reset (asynchronous assert): all outputs, pipeline valids, tags, counter and state go to 0/IDLE. Reset mid-frame drops that frame; no out_valid until a new frame completes after release.
- Beats with in_valid=0 are ignored; in_first/in_last are don't-care then.
- Beat counter saturates at 2^INDEX_W-1 (out_overflow already set).

## Structure
- Package maxsearch_pkg:
  - ge_signed compare function (tie rule as above)
  - clog2
  - node struct type (value, lane index, tag) parametrised by WIDTH/INDEX_W via localparams in the module
- Sub-module max_pair_stage: one tree level, NUM_IN/2^(k+1) registered pairwise compares. It is instantiated L times via generate.
- Top module: level generate, beat counter, frame state machine, accumulator, output register.

## Test plan
- NUM_IN=4, single-beat frame with lanes {a=5, b=-3, c=7, d=7} (8-bit) → out_valid at T+3, out_max=7, out_index=2 (tie to lower).
- All-negative lanes {-1, -128, -2, -1} → out_max=-1, out_index=0. Checks that negative ties do not pick the higher lane.
- NUM_IN=4, INDEX_OFFSET=0, 16-beat frame, single max 100 in beat 11 lane 3, everything else 0 → out_index=47, out_overflow=0, exactly one out_valid pulse.
- INDEX_OFFSET=8, 16-beat frame, max in beat 15 lane 2 → out_index=(62+8) mod 64=6, out_overflow=1.
- Frame A open for 3 beats, then in_first starts frame B (2 beats, max 20 at global index 5) → only one out_valid, reporting 20/index 5. Back-to-back single-beat frames every cycle → one pulse per cycle.
- Assert reset_n low mid-frame for one cycle → outputs 0 immediately; the next complete frame reports correctly with no stray pulse.

Source files
------------

// File: rtl/maxsearch_pkg.sv
// Shared types and helpers for the pipelined maximum-search tree.
package maxsearch_pkg;

    // Width of the common signed compare path; metrics up to this width are supported.
    localparam int CMP_W = 32;

    // Beat tag carried alongside every tree node.
    typedef struct packed {
        logic first;
        logic last;
        logic valid;
    } tag_t;

    // Frame tracking states.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Signed a >= b. The caller passes the lower-index candidate as a,
    // so equality keeps the lower index.
    function automatic logic ge_signed(input logic signed [CMP_W-1:0] a,
                                       input logic signed [CMP_W-1:0] b);
        return (a >= b);
    endfunction

endpackage

// File: rtl/max_pair_stage.sv
// One level of the comparison tree: N_OUT registered pairwise maxima.
module max_pair_stage
    import maxsearch_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANE_W = 2,
    parameter int N_OUT  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2*N_OUT*WIDTH-1:0]  in_val,
    input  logic [2*N_OUT*LANE_W-1:0] in_lane,
    input  tag_t                      in_tag,
    output logic [N_OUT*WIDTH-1:0]    out_val,
    output logic [N_OUT*LANE_W-1:0]   out_lane,
    output tag_t                      out_tag
);

    logic [N_OUT*WIDTH-1:0]  win_val;
    logic [N_OUT*LANE_W-1:0] win_lane;

    // Pairwise select; the even (lower-lane) input wins ties.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        win_val  = '0;
        win_lane = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (ge_signed(CMP_W'($signed(in_val[(2*j)*WIDTH +: WIDTH])),
                          CMP_W'($signed(in_val[(2*j+1)*WIDTH +: WIDTH])))) begin
                win_val[j*WIDTH +: WIDTH]    = in_val[(2*j)*WIDTH +: WIDTH];
                win_lane[j*LANE_W +: LANE_W] = in_lane[(2*j)*LANE_W +: LANE_W];
            end else begin
                win_val[j*WIDTH +: WIDTH]    = in_val[(2*j+1)*WIDTH +: WIDTH];
                win_lane[j*LANE_W +: LANE_W] = in_lane[(2*j+1)*LANE_W +: LANE_W];
            end
        end
    end

    // Tag register: valid/first/last must clear on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) out_tag <= '0;
        else          out_tag <= in_tag;
    end

    // Datapath register.
    // NOTE: values and lanes are not reset; they are only consumed under a valid tag.
    always_ff @(posedge clk) begin
        out_val  <= win_val;
        out_lane <= win_lane;
    end

endmodule

// File: rtl/max_search_tree.sv
// Pipelined signed maximum search with index reporting over multi-beat frames.
module max_search_tree
    import maxsearch_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NUM_IN       = 4,
    parameter int INDEX_W      = 6,
    parameter int INDEX_OFFSET = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_max,
    output logic [INDEX_W-1:0]      out_index,
    output logic                    out_overflow
);

    localparam int L      = clog2(NUM_IN);
    localparam int LANE_W = L;

    // Tree output node.
    typedef struct packed {
        logic [WIDTH-1:0]  value;
        logic [LANE_W-1:0] lane;
        tag_t              tag;
    } node_t;

    state_t               state_q, state_d;
    logic                 eff_first;
    logic [INDEX_W-1:0]   beat_cnt, cur_beat, beat_nxt;
    logic                 beat_ovf;
    tag_t                 tag0;
    logic [NUM_IN*LANE_W-1:0] lane0;

    logic [INDEX_W-1:0]   beat_pipe [L];
    logic                 ovf_pipe  [L];

    node_t                t;
    logic [WIDTH-1:0]     acc_val;
    logic [INDEX_W-1:0]   acc_idx;
    logic                 acc_ovf;
    logic                 take;
    logic [INDEX_W-1:0]   t_index;
    logic [WIDTH-1:0]     nxt_val;
    logic [INDEX_W-1:0]   nxt_idx;
    logic                 nxt_ovf;

    // Lane numbers entering the tree.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        assign lane0[i*LANE_W +: LANE_W] = LANE_W'(i);
    end

    // Frame FSM next state, effective first-beat and beat index/overflow of the incoming beat.
    always_comb begin
        state_d   = state_q;
        eff_first = in_valid && (in_first || (state_q == IDLE));
        if (in_valid) state_d = in_last ? IDLE : ACTIVE;
        cur_beat  = eff_first ? '0 : beat_cnt;
        beat_nxt  = (&cur_beat) ? cur_beat : cur_beat + 1'b1;
        beat_ovf  = (int'(cur_beat) * NUM_IN + NUM_IN - 1 + INDEX_OFFSET) >= (1 << INDEX_W);
        tag0.first = eff_first;
        tag0.last  = in_valid && in_last;
        tag0.valid = in_valid;
    end

    // Frame state and saturating beat counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            beat_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (in_valid) beat_cnt <= beat_nxt;
        end
    end

    // Comparison tree, one registered level per generate iteration.
    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int N_OUT = NUM_IN >> (k + 1);
        logic [N_OUT*WIDTH-1:0]  val;
        logic [N_OUT*LANE_W-1:0] lane;
        tag_t                    tag;
        if (k == 0) begin : g_root
            max_pair_stage #(.WIDTH(WIDTH), .LANE_W(LANE_W), .N_OUT(N_OUT)) u_stage (
                .clk      (clk),
                .reset_n  (reset_n),
                .in_val   (in_data),
                .in_lane  (lane0),
                .in_tag   (tag0),
                .out_val  (val),
                .out_lane (lane),
                .out_tag  (tag)
            );
        end else begin : g_next
            max_pair_stage #(.WIDTH(WIDTH), .LANE_W(LANE_W), .N_OUT(N_OUT)) u_stage (
                .clk      (clk),
                .reset_n  (reset_n),
                .in_val   (g_lvl[k-1].val),
                .in_lane  (g_lvl[k-1].lane),
                .in_tag   (g_lvl[k-1].tag),
                .out_val  (val),
                .out_lane (lane),
                .out_tag  (tag)
            );
        end
    end

    assign t.value = g_lvl[L-1].val;
    assign t.lane  = g_lvl[L-1].lane;
    assign t.tag   = g_lvl[L-1].tag;

    // Beat number and overflow flag travel beside the tree to stay aligned with its winner.
    always_ff @(posedge clk) begin
        beat_pipe[0] <= cur_beat;
        ovf_pipe[0]  <= beat_ovf;
        for (int k = 1; k < L; k++) begin
            beat_pipe[k] <= beat_pipe[k-1];
            ovf_pipe[k]  <= ovf_pipe[k-1];
        end
    end

    // Accumulator update: load on first beat, otherwise replace only on a strictly greater value.
    always_comb begin
        t_index = INDEX_W'(int'(beat_pipe[L-1]) * NUM_IN + int'(t.lane) + INDEX_OFFSET);
        take    = t.tag.first || !ge_signed(CMP_W'($signed(acc_val)), CMP_W'($signed(t.value)));
        nxt_val = take ? t.value : acc_val;
        nxt_idx = take ? t_index : acc_idx;
        nxt_ovf = ovf_pipe[L-1] | (t.tag.first ? 1'b0 : acc_ovf);
    end

    // Running maximum and frame result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_val      <= '0;
            acc_idx      <= '0;
            acc_ovf      <= 1'b0;
            out_valid    <= 1'b0;
            out_max      <= '0;
            out_index    <= '0;
            out_overflow <= 1'b0;
        end else begin
            out_valid <= t.tag.valid && t.tag.last;
            if (t.tag.valid) begin
                acc_val <= nxt_val;
                acc_idx <= nxt_idx;
                acc_ovf <= nxt_ovf;
            end
            if (t.tag.valid && t.tag.last) begin
                out_max      <= nxt_val;
                out_index    <= nxt_idx;
                out_overflow <= nxt_ovf;
            end
        end
    end

endmodule
